hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised, multi-cycle successor of the pipeline hazard unit for the 5-stage pipeline.
- Owns three functions:
  - E-stage forwarding, plus new D-stage forwarding for early branch resolution.
  - Load-use stalling with a configurable bubble count, for deeper memory stages.
  - A scoreboard/counter that stalls dependents of an in-flight multi-cycle multiply/divide unit (MDU).
- Sits beside the datapath and drives stall/flush/forward selects to the F/D/E pipeline registers.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_BUBBLES, 1, bubbles inserted on load-use (>=1).
- MDU_LATENCY, 4, cycles from MDU issue in E until its result is forwardable (>=1).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- RsD, RtD  in  REG_AW  D-stage source regs.
- RsE, RtE  in  REG_AW  E-stage source regs.
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination regs per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage.
- MemtoRegE, MemtoRegM  in  1  load in E / M.
- BranchD  in  1  branch resolving in D.
- PCSrcD  in  1  branch taken (valid only with BranchD).
- MduStartE  in  1  MDU op issuing from E this cycle.
- MduDstE  in  REG_AW  MDU destination reg.
- MduOpD  in  1  D-stage instruction is an MDU op.
- ForwardAE, ForwardBE  out  2  00 regfile, 01 W result, 10 M result.
- ForwardAD, ForwardBD  out  1  1 = use M result in D comparator.
- StallF, StallD  out  1  hold PC / D register.
- FlushE  out  1  insert bubble into E.
- FlushD  out  1  squash D (taken branch).
- MduBusy  out  1  MDU counter nonzero.

Behaviour:
- Reset (rst_n=0, async): lu_cnt=0, mdu_cnt=0, mdu_dst=0.
  - All outputs then follow the combinational rules below with counters at 0.
  - Stall/flush depend on the inputs only, via load-use, branch and MDU detects.
- Register 0 never matches in any comparison below.
- Forwarding:
  - ForwardAE=10 if RsE==WriteRegM && RegWriteM.
  - Else 01 if RsE==WriteRegW && RegWriteW.
  - Else 00.
  - M has priority over W. ForwardBE uses RtE the same way.
  - ForwardAD=1 iff RsD==WriteRegM && RegWriteM && !MemtoRegM. ForwardBD uses RtD the same way.
- lu_det = MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
  - On the clock with lu_det && lu_cnt==0: lu_cnt <= LOAD_BUBBLES-1.
  - While lu_cnt!=0: lu_cnt decrements by 1 per clock.
  - lustall = lu_det || lu_cnt!=0.
  - Total bubbles = exactly LOAD_BUBBLES.
- brstall = BranchD && one of:
  - RegWriteE && WriteRegE in {RsD,RtD}, or
  - MemtoRegM && WriteRegM in {RsD,RtD}.
- MDU scoreboard:
  - On MduStartE && !FlushE: mdu_cnt <= MDU_LATENCY, mdu_dst <= MduDstE.
  - Else, if mdu_cnt!=0: decrement.
  - MduBusy = (mdu_cnt!=0).
  - mdustall = MduBusy && (MduOpD || (mdu_dst!=0 && mdu_dst in {RsD,RtD})).
  - A new MduStartE while busy cannot occur (D is held). If presented anyway, it reloads the counter (last issue wins).
- stall = lustall || brstall || mdustall.
- Outputs:
  - StallF = StallD = FlushE = stall.
  - FlushD = BranchD && PCSrcD && !stall. A stalled branch re-resolves the next cycle.
- Simultaneous lu_det and mdustall: both counters advance independently. Stall holds until both clear.
- Reset mid-stall: counters clear immediately (async). Stall deasserts unless combinational detects remain true.
- Counter width: $clog2(max(LOAD_BUBBLES, MDU_LATENCY)+1). No wrap; counters saturate at 0.

Test Plan:
- Forward priority: RsE=RtE=3, WriteRegM=WriteRegW=3, RegWriteM=RegWriteW=1 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> 01. RsE=0 -> 00.
- Load-use, LOAD_BUBBLES=3: MemtoRegE=1, RtE=5, RsD=5 for one cycle (then E flushed) -> StallF/StallD/FlushE high exactly 3 consecutive cycles, then low.
- Branch hazard: BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7 -> stall 1 cycle, FlushD=0. Next cycle with the producer in M (ALU) -> ForwardAD=1, stall=0, and PCSrcD=1 gives FlushD=1.
- MDU, MDU_LATENCY=4: MduStartE, MduDstE=9; next D reads RtD=9 -> MduBusy 4 cycles, stall 4 cycles. An unrelated RsD=2 in D -> no stall. MduOpD=1 while busy -> stall.
- Reset mid-operation: assert rst_n=0 with lu_cnt=2, mdu_cnt=3 -> MduBusy=0 and counters 0 without a clock edge. Stall follows inputs only.
- Concurrent: lu_det and mdustall overlapping -> stall stays high until the later of the two counters expires. No spurious FlushD.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline with E/D forwarding, multi-bubble load-use
// stalling and a countdown scoreboard for the multi-cycle multiply/divide unit.
module hazard_unit_mc #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MDU_LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] MduDstE,
  input  logic              MduOpD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              FlushD,
  output logic              MduBusy
);

  localparam int unsigned MaxCnt = (LOAD_BUBBLES > MDU_LATENCY) ? LOAD_BUBBLES : MDU_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  logic [CntW-1:0]   lu_cnt_q, lu_cnt_d;
  logic [CntW-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic [REG_AW-1:0] mdu_dst_q, mdu_dst_d;

  logic lu_det, lustall, brstall, mdustall, stall;

  // Register 0 is hardwired and never a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    if (hit(RsE, WriteRegM) && RegWriteM)      ForwardAE = 2'b10;
    else if (hit(RsE, WriteRegW) && RegWriteW) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (hit(RtE, WriteRegM) && RegWriteM)      ForwardBE = 2'b10;
    else if (hit(RtE, WriteRegW) && RegWriteW) ForwardBE = 2'b01;

    ForwardAD = hit(RsD, WriteRegM) && RegWriteM && !MemtoRegM;
    ForwardBD = hit(RtD, WriteRegM) && RegWriteM && !MemtoRegM;
  end

  always_comb begin
    lu_det  = MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
    lustall = lu_det || (lu_cnt_q != '0);

    brstall = BranchD &&
              ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
               (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));

    MduBusy  = (mdu_cnt_q != '0);
    mdustall = MduBusy && (MduOpD || hit(mdu_dst_q, RsD) || hit(mdu_dst_q, RtD));

    stall  = lustall || brstall || mdustall;
    StallF = stall;
    StallD = stall;
    FlushE = stall;
    FlushD = BranchD && PCSrcD && !stall;
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (lu_cnt_q != '0) lu_cnt_d = lu_cnt_q - CntW'(1);
    else if (lu_det)    lu_cnt_d = CntW'(LOAD_BUBBLES - 1);

    mdu_cnt_d = mdu_cnt_q;
    mdu_dst_d = mdu_dst_q;
    // A flushed E slot never really issues, so it must not arm the scoreboard.
    if (MduStartE && !stall) begin
      mdu_cnt_d = CntW'(MDU_LATENCY);
      mdu_dst_d = MduDstE;
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      mdu_cnt_q <= '0;
      mdu_dst_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      mdu_dst_q <= mdu_dst_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (LOAD_BUBBLES=3, MDU_LATENCY=4); expected output
// vectors are queued as each step is driven and popped when the outputs are sampled.
module tb_hazard_unit_mc;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduDstE;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic          BranchD, PCSrcD, MduStartE, MduOpD;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD, StallF, StallD, FlushE, FlushD, MduBusy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_AW      (AW),
    .LOAD_BUBBLES(3),
    .MDU_LATENCY (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RsD      (RsD),
    .RtD      (RtD),
    .RsE      (RsE),
    .RtE      (RtE),
    .WriteRegE(WriteRegE),
    .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .MemtoRegM(MemtoRegM),
    .BranchD  (BranchD),
    .PCSrcD   (PCSrcD),
    .MduStartE(MduStartE),
    .MduDstE  (MduDstE),
    .MduOpD   (MduOpD),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushE   (FlushE),
    .FlushD   (FlushD),
    .MduBusy  (MduBusy)
  );

  // {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, FlushD, MduBusy}
  function automatic logic [10:0] ex(input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd, input logic stl,
                                     input logic fld, input logic busy);
    return {fae, fbe, fad, fbd, stl, stl, stl, fld, busy};
  endfunction

  task automatic clr();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0; MduDstE = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; MduStartE = 0; MduOpD = 0;
  endtask

  task automatic chk(input string tag, input logic [10:0] e);
    logic [10:0] obs, want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    obs  = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, FlushD, MduBusy};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", t, obs, want);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #12;
    chk("reset_idle", ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;

    // Forwarding priority and register-0 exclusion
    nxt(); RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
    chk("fwd_m_prio", ex(2'b10, 2'b10, 0, 0, 0, 0, 0));
    RegWriteM = 0;
    chk("fwd_w", ex(2'b01, 2'b01, 0, 0, 0, 0, 0));
    RsE = 0;
    chk("fwd_rs0", ex(2'b00, 2'b01, 0, 0, 0, 0, 0));
    nxt(); RsD = 4; RtD = 4; WriteRegM = 4; RegWriteM = 1; MemtoRegM = 1;
    chk("fwdd_load_blocked", ex(0, 0, 0, 0, 0, 0, 0));
    MemtoRegM = 0;
    chk("fwdd_alu", ex(0, 0, 1, 1, 0, 0, 0));

    // Load-use: exactly three bubbles
    nxt(); MemtoRegE = 1; RtE = 5; RsD = 5;
    chk("lu_c0", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); RsD = 5; chk("lu_c1", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); RsD = 5; chk("lu_c2", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); RsD = 5; chk("lu_done", ex(0, 0, 0, 0, 0, 0, 0));

    // Branch hazard, then forwarded resolution
    nxt(); BranchD = 1; PCSrcD = 1; RsD = 7; RegWriteE = 1; WriteRegE = 7;
    chk("br_stall", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); BranchD = 1; PCSrcD = 1; RsD = 7; RegWriteM = 1; WriteRegM = 7;
    chk("br_fwd_taken", ex(0, 0, 1, 0, 0, 1, 0));
    MemtoRegM = 1;
    chk("br_load_m", ex(0, 0, 0, 0, 1, 0, 0));

    // MDU scoreboard: dependent on RtD stalls for the full latency
    nxt(); MduStartE = 1; MduDstE = 9;
    chk("mdu_issue", ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      nxt(); RtD = 9;
      chk($sformatf("mdu_dep_%0d", i), ex(0, 0, 0, 0, 1, 0, 1));
    end
    nxt(); RtD = 9; chk("mdu_free", ex(0, 0, 0, 0, 0, 0, 0));

    nxt(); MduStartE = 1; MduDstE = 9;
    chk("mdu_issue2", ex(0, 0, 0, 0, 0, 0, 0));
    nxt(); RsD = 2; chk("mdu_unrelated", ex(0, 0, 0, 0, 0, 0, 1));
    nxt(); RsD = 2; MduOpD = 1; chk("mdu_op_d", ex(0, 0, 0, 0, 1, 0, 1));
    nxt(); chk("mdu_cnt2", ex(0, 0, 0, 0, 0, 0, 1));
    nxt(); chk("mdu_cnt1", ex(0, 0, 0, 0, 0, 0, 1));
    nxt(); chk("mdu_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // An MDU issue squashed by FlushE must not arm the scoreboard
    nxt(); MduStartE = 1; MduDstE = 9; MemtoRegE = 1; RtE = 5; RsD = 5;
    chk("mdu_flushed", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); chk("mdu_flushed_lu1", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); chk("mdu_flushed_lu2", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); chk("mdu_flushed_end", ex(0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset with both counters loaded
    nxt(); MduStartE = 1; MduDstE = 9;
    chk("rst_arm_mdu", ex(0, 0, 0, 0, 0, 0, 0));
    nxt(); MemtoRegE = 1; RtE = 5; RsD = 5;
    chk("rst_arm_lu", ex(0, 0, 0, 0, 1, 0, 1));
    nxt(); chk("rst_before", ex(0, 0, 0, 0, 1, 0, 1));
    rst_n = 1'b0;
    chk("rst_async", ex(0, 0, 0, 0, 0, 0, 0));
    nxt(); MemtoRegE = 1; RtE = 5; RsD = 5;
    chk("rst_comb_detect", ex(0, 0, 0, 0, 1, 0, 0));
    nxt(); rst_n = 1'b1;
    chk("rst_release", ex(0, 0, 0, 0, 0, 0, 0));

    // Overlapping load-use and MDU stalls, branch waiting behind them
    nxt(); MduStartE = 1; MduDstE = 9;
    chk("cc_issue", ex(0, 0, 0, 0, 0, 0, 0));
    nxt(); RtD = 9; MemtoRegE = 1; RtE = 9; BranchD = 1; PCSrcD = 1;
    chk("cc_both", ex(0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      nxt(); RtD = 9; BranchD = 1; PCSrcD = 1;
      chk($sformatf("cc_hold_%0d", i), ex(0, 0, 0, 0, 1, 0, 1));
    end
    nxt(); RtD = 9; BranchD = 1; PCSrcD = 1;
    chk("cc_release", ex(0, 0, 0, 0, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
